grid_vga_renderer: RTL and testbench



---
 rtl/grid_display_pkg.sv | 41 ++++
 rtl/vga_timing.sv | 77 +++++++
 rtl/grid_vga_renderer.sv | 170 +++++++++++++++++
 tb/tb_grid_vga_renderer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_display_pkg.sv
// Shared display/grid definitions.
//   - 640x480@60 VGA timing constants (active, front porch, sync, back porch, total)
//   - grid geometry (GRID_N cells per side) and default colours
//   - idx(col,row): flattened occupancy bit index, shared with the game-logic block
package grid_display_pkg;

    // Horizontal timing, in pixels.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter width; large enough for any timing with totals up to 1024.
    localparam int CNT_W = 10;

    // Grid geometry.
    localparam int GRID_N = 16;
    localparam int CELL_W = $clog2(GRID_N);
    localparam int IDX_W  = $clog2(GRID_N * GRID_N);

    typedef logic [11:0] rgb_t;

    localparam rgb_t FG_RGB   = 12'hFFF;
    localparam rgb_t BG_RGB   = 12'h000;
    localparam rgb_t LINE_RGB = 12'h444;

    // Occupancy bit for the cell at column col, row row (row 0 = top).
    function automatic logic [IDX_W-1:0] idx(input logic [CELL_W-1:0] col,
                                             input logic [CELL_W-1:0] row);
        return IDX_W'(col) * IDX_W'(GRID_N) + IDX_W'(row);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator.
//   clk, reset   : system clock, synchronous active-high reset
//   pix_en       : one-clk-in-four pixel enable
//   hcount/vcount: current raster position (advance on pix_en)
//   hsync_raw, vsync_raw : unregistered active-low syncs for the current position
//   active_raw   : current position lies in the visible area
//   line_last    : hcount is on the last column of a line
//   frame_wrap   : pix_en on the very last pixel of the frame (one clk)
module vga_timing
    import grid_display_pkg::*;
#(
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FPORCH = H_FP,
    parameter int H_SPULSE = H_SYNC,
    parameter int H_BPORCH = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FPORCH = V_FP,
    parameter int V_SPULSE = V_SYNC,
    parameter int V_BPORCH = V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             active_raw,
    output logic             line_last,
    output logic             frame_wrap
);

    localparam int H_TOT = H_ACT + H_FPORCH + H_SPULSE + H_BPORCH;
    localparam int V_TOT = V_ACT + V_FPORCH + V_SPULSE + V_BPORCH;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACT + H_FPORCH);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FPORCH + H_SPULSE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACT + V_FPORCH);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FPORCH + V_SPULSE);

    logic [1:0] div_q;
    logic       v_last;

    // 100 MHz / 4 = 25 MHz pixel rate; the enable fires on the last divider phase.
    assign pix_en = (div_q == 2'd3);

    assign line_last  = (hcount == H_LAST);
    assign v_last     = (vcount == V_LAST);
    assign frame_wrap = pix_en && line_last && v_last;

    assign hsync_raw  = !((hcount >= HS_START) && (hcount < HS_END));
    assign vsync_raw  = !((vcount >= VS_START) && (vcount < VS_END));
    assign active_raw = (hcount < H_VIS) && (vcount < V_VIS);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 2'd0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            div_q <= div_q + 2'd1;
            if (pix_en) begin
                if (line_last) begin
                    hcount <= '0;
                    vcount <= v_last ? '0 : vcount + CNT_W'(1);
                end else begin
                    hcount <= hcount + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/grid_vga_renderer.sv
// Renders a 16x16 occupancy grid on a VGA display.
//   clk, reset  : 100 MHz system clock, synchronous active-high reset
//   grid_in     : occupancy, bit (col*16 + row), row 0 at the top
//   hsync/vsync : active-low syncs
//   rgb         : {R,G,B} 4 bits each
//   de          : visible-area enable
//   frame_start : one-clk pulse when the grid snapshot is taken
// The grid is sampled once per frame (on the final pixel) so a frame never
// shows a mix of two grid states. All pixel outputs are registered from the
// same raster position, so sync, de and colour share one pixel of latency.
// GRID_N comes from grid_display_pkg and fixes the grid_in width.
module grid_vga_renderer
    import grid_display_pkg::*;
#(
    parameter int   CELL_PX    = 30,
    parameter int   GRID_X0    = 80,
    parameter rgb_t FG_COLOR   = FG_RGB,
    parameter rgb_t BG_COLOR   = BG_RGB,
    parameter rgb_t LINE_COLOR = LINE_RGB,
    parameter int   H_ACT      = H_ACTIVE,
    parameter int   H_FPORCH   = H_FP,
    parameter int   H_SPULSE   = H_SYNC,
    parameter int   H_BPORCH   = H_BP,
    parameter int   V_ACT      = V_ACTIVE,
    parameter int   V_FPORCH   = V_FP,
    parameter int   V_SPULSE   = V_SYNC,
    parameter int   V_BPORCH   = V_BP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [GRID_N*GRID_N-1:0] grid_in,
    output logic                     hsync,
    output logic                     vsync,
    output logic [11:0]              rgb,
    output logic                     de,
    output logic                     frame_start
);

    localparam int GRID_PX = GRID_N * CELL_PX;
    localparam int SUB_W   = $clog2(CELL_PX + 1);
    localparam int H_TOT   = H_ACT + H_FPORCH + H_SPULSE + H_BPORCH;

    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CELL_PX - 1);
    localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(GRID_N - 1);
    localparam logic [CNT_W-1:0]  X_START   = CNT_W'(GRID_X0);
    localparam logic [CNT_W-1:0]  X_END     = CNT_W'(GRID_X0 + GRID_PX);
    localparam logic [CNT_W-1:0]  Y_END     = CNT_W'(GRID_PX);
    localparam logic [CNT_W-1:0]  ROW_STOP  = CNT_W'(V_ACT - 1);
    // Column trackers are loaded one pixel ahead so they read 0 at GRID_X0.
    localparam logic [CNT_W-1:0]  X_LOAD    = CNT_W'((GRID_X0 == 0) ? H_TOT - 1 : GRID_X0 - 1);

    logic             pix_en;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             active_raw;
    logic             line_last;
    logic             frame_wrap;

    vga_timing #(
        .H_ACT    (H_ACT),
        .H_FPORCH (H_FPORCH),
        .H_SPULSE (H_SPULSE),
        .H_BPORCH (H_BPORCH),
        .V_ACT    (V_ACT),
        .V_FPORCH (V_FPORCH),
        .V_SPULSE (V_SPULSE),
        .V_BPORCH (V_BPORCH)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hcount     (hcount),
        .vcount     (vcount),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw),
        .active_raw (active_raw),
        .line_last  (line_last),
        .frame_wrap (frame_wrap)
    );

    logic [GRID_N*GRID_N-1:0] snap;
    logic [SUB_W-1:0]         col_sub;
    logic [SUB_W-1:0]         row_sub;
    logic [CELL_W-1:0]        cell_col;
    logic [CELL_W-1:0]        cell_row;
    logic [IDX_W-1:0]         cell_idx;
    logic                     in_grid;
    rgb_t                     pix_rgb;

    // Frame snapshot: taken on the last pixel of the frame, held for the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                snap <= grid_in;
            end
        end
    end

    // Cell position tracking by counting, so no divide by CELL_PX is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_sub  <= '0;
            cell_col <= '0;
            row_sub  <= '0;
            cell_row <= '0;
        end else if (pix_en) begin
            if (hcount == X_LOAD) begin
                col_sub  <= '0;
                cell_col <= '0;
            end else if (col_sub == SUB_LAST) begin
                col_sub  <= '0;
                cell_col <= (cell_col == CELL_LAST) ? '0 : cell_col + CELL_W'(1);
            end else begin
                col_sub <= col_sub + SUB_W'(1);
            end

            // Rows advance at end of line; frame_wrap reloads them for line 0.
            if (frame_wrap) begin
                row_sub  <= '0;
                cell_row <= '0;
            end else if (line_last && (vcount < ROW_STOP)) begin
                if (row_sub == SUB_LAST) begin
                    row_sub  <= '0;
                    cell_row <= (cell_row == CELL_LAST) ? '0 : cell_row + CELL_W'(1);
                end else begin
                    row_sub <= row_sub + SUB_W'(1);
                end
            end
        end
    end

    // Colour selection, highest priority first.
    always_comb begin
        in_grid  = (hcount >= X_START) && (hcount < X_END) && (vcount < Y_END);
        cell_idx = idx(cell_col, cell_row);
        pix_rgb  = 12'h000;
        if (!active_raw) begin
            pix_rgb = 12'h000;
        end else if (!in_grid) begin
            pix_rgb = BG_COLOR;
        end else if ((col_sub == '0) || (row_sub == '0)) begin
            pix_rgb = LINE_COLOR;
        end else if (snap[cell_idx]) begin
            pix_rgb = FG_COLOR;
        end else begin
            pix_rgb = BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            rgb   <= 12'h000;
        end else if (pix_en) begin
            hsync <= hsync_raw;
            vsync <= vsync_raw;
            de    <= active_raw;
            rgb   <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Bench for grid_vga_renderer: one instance at full 640x480 timing for
// sync/de timing and geometry on the first lines, one instance with a
// shrunken raster (48x36 total, 2-px cells) so several whole frames fit.
module tb_grid_vga_renderer;

    typedef struct {
        int inst;
        int x;
        int y;
        int f;
    } probe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_d = 1'b1;
    logic         reset_s = 1'b1;
    logic [255:0] grid_d  = '0;
    logic [255:0] grid_s  = '0;

    logic        hsync_d, vsync_d, de_d, fs_d;
    logic [11:0] rgb_d;
    logic        hsync_s, vsync_s, de_s, fs_s;
    logic [11:0] rgb_s;

    grid_vga_renderer u_dut_def (
        .clk         (clk),
        .reset       (reset_d),
        .grid_in     (grid_d),
        .hsync       (hsync_d),
        .vsync       (vsync_d),
        .rgb         (rgb_d),
        .de          (de_d),
        .frame_start (fs_d)
    );

    grid_vga_renderer #(
        .CELL_PX (2),  .GRID_X0 (6),
        .H_ACT   (40), .H_FPORCH (2), .H_SPULSE (4), .H_BPORCH (2),
        .V_ACT   (32), .V_FPORCH (1), .V_SPULSE (2), .V_BPORCH (1)
    ) u_dut_small (
        .clk         (clk),
        .reset       (reset_s),
        .grid_in     (grid_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .rgb         (rgb_s),
        .de          (de_s),
        .frame_start (fs_s)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rel[2];
    int fs_cnt_d    = 0;
    int fs_cnt_s    = 0;

    probe_t      probe_q[$];
    logic [14:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fs_d === 1'b1) fs_cnt_d++;
        if (fs_s === 1'b1) fs_cnt_s++;
    end

    function automatic int htot(input int inst);
        return (inst == 0) ? 800 : 48;
    endfunction

    function automatic int vtot(input int inst);
        return (inst == 0) ? 525 : 36;
    endfunction

    // Expected {hsync, vsync, de, rgb} for raster position (x,y).
    function automatic logic [14:0] model_px(input int inst, input int x, input int y,
                                             input logic [255:0] pat);
        int ha, hfp, hsw, va, vfp, vsw, x0, c;
        logic hs, vs, act;
        logic [11:0] col;
        if (inst == 0) begin
            ha = 640; hfp = 16; hsw = 96; va = 480; vfp = 10; vsw = 2; x0 = 80; c = 30;
        end else begin
            ha = 40;  hfp = 2;  hsw = 4;  va = 32;  vfp = 1;  vsw = 2; x0 = 6;  c = 2;
        end
        hs  = !((x >= ha + hfp) && (x < ha + hfp + hsw));
        vs  = !((y >= va + vfp) && (y < va + vfp + vsw));
        act = (x < ha) && (y < va);
        if (!act)                                        col = 12'h000;
        else if (x < x0 || x >= x0 + 16 * c || y >= 16 * c) col = 12'h000;
        else if (((x - x0) % c) == 0 || (y % c) == 0)    col = 12'h444;
        else if (pat[((x - x0) / c) * 16 + (y / c)])     col = 12'hFFF;
        else                                             col = 12'h000;
        return {hs, vs, act, col};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to #1 after clk edge number 'target' counted from that instance's reset release.
    task automatic wait_rel(input int inst, input int target);
        if (cyc - rel[inst] > target) begin
            check("probe_order", 32'(cyc - rel[inst]), 32'(target));
        end
        while (cyc - rel[inst] < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_probe(input int inst, input int x, input int y, input int f,
                              input logic [255:0] pat);
        probe_t p;
        p.inst = inst; p.x = x; p.y = y; p.f = f;
        probe_q.push_back(p);
        exp_q.push_back(model_px(inst, x, y, pat));
    endtask

    task automatic drain();
        probe_t      p;
        logic [14:0] e;
        logic [14:0] o;
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            e = exp_q.pop_front();
            wait_rel(p.inst, 4 * (p.f * htot(p.inst) * vtot(p.inst) + p.y * htot(p.inst) + p.x + 1));
            o = (p.inst == 0) ? {hsync_d, vsync_d, de_d, rgb_d} : {hsync_s, vsync_s, de_s, rgb_s};
            check($sformatf("%s_px(%0d,%0d)f%0d", (p.inst == 0) ? "def" : "small", p.x, p.y, p.f),
                  32'(o), 32'(e));
        end
    endtask

    // Wait (bounded) for hsync_d (sel 0) or de_d (sel 1) to reach lvl; returns cycle count.
    task automatic wait_lvl(input int sel, input logic lvl, output int t);
        int n;
        n = 0;
        while ((((sel == 0) ? hsync_d : de_d) !== lvl) && (n < 4000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        t = cyc;
    endtask

    localparam int HV_S = 48 * 36;

    initial begin
        logic [255:0] pat_0;
        logic [255:0] pat_a;
        logic [255:0] pat_b;
        int t1, t2, t3, t4, t5;

        pat_0 = '0;
        pat_a = '0; pat_a[0] = 1'b1; pat_a[15] = 1'b1;
        pat_b = '0; pat_b[255] = 1'b1;
        rel[0] = 0;
        rel[1] = 0;

        // Reset values on both instances.
        repeat (10) @(posedge clk);
        #1;
        check("rst_hsync_d", 32'(hsync_d), 32'd1);
        check("rst_vsync_d", 32'(vsync_d), 32'd1);
        check("rst_rgb_d",   32'(rgb_d),   32'd0);
        check("rst_de_d",    32'(de_d),    32'd0);
        check("rst_fs_d",    32'(fs_d),    32'd0);
        check("rst_hsync_s", 32'(hsync_s), 32'd1);
        check("rst_vsync_s", 32'(vsync_s), 32'd1);
        check("rst_rgb_s",   32'(rgb_s),   32'd0);
        check("rst_de_s",    32'(de_s),    32'd0);
        check("rst_fs_s",    32'(fs_s),    32'd0);

        // ---- Full-timing instance ----
        reset_d = 1'b0;
        rel[0]  = cyc;
        push_probe(0, 40,  0, 0, pat_0);
        push_probe(0, 79,  0, 0, pat_0);
        push_probe(0, 80,  0, 0, pat_0);
        push_probe(0, 81,  0, 0, pat_0);
        push_probe(0, 559, 0, 0, pat_0);
        push_probe(0, 560, 0, 0, pat_0);
        push_probe(0, 639, 0, 0, pat_0);
        push_probe(0, 640, 0, 0, pat_0);
        drain();

        wait_lvl(0, 1'b0, t1);
        check("hsync_first_fall", 32'(t1 - rel[0]), 32'd2628);
        wait_lvl(0, 1'b1, t2);
        check("hsync_low_clks", 32'(t2 - t1), 32'd384);
        wait_lvl(0, 1'b0, t3);
        check("line_period_clks", 32'(t3 - t1), 32'd3200);
        wait_lvl(1, 1'b1, t4);
        wait_lvl(1, 1'b0, t5);
        check("de_pixels_per_line", 32'((t5 - t4) / 4), 32'd640);
        check("vsync_d_high_early", 32'(vsync_d), 32'd1);
        check("fs_d_none_early", 32'(fs_cnt_d), 32'd0);

        // ---- Small instance: frame 0 shows an empty grid ----
        reset_s = 1'b0;
        rel[1]  = cyc;
        grid_s  = pat_a;
        push_probe(1, 6,  0,  0, pat_0);
        push_probe(1, 41, 0,  0, pat_0);
        push_probe(1, 42, 0,  0, pat_0);
        push_probe(1, 45, 0,  0, pat_0);
        push_probe(1, 46, 0,  0, pat_0);
        push_probe(1, 7,  1,  0, pat_0);
        push_probe(1, 7,  31, 0, pat_0);
        push_probe(1, 0,  32, 0, pat_0);
        push_probe(1, 0,  33, 0, pat_0);
        push_probe(1, 0,  34, 0, pat_0);
        push_probe(1, 0,  35, 0, pat_0);
        drain();

        // frame_start: exactly one clk wide, on the snapshot edge.
        wait_rel(1, 4 * HV_S - 1);
        check("fs_before", 32'(fs_s), 32'd0);
        wait_rel(1, 4 * HV_S);
        check("fs_pulse", 32'(fs_s), 32'd1);
        wait_rel(1, 4 * HV_S + 1);
        check("fs_after", 32'(fs_s), 32'd0);

        // Frame 1 renders pattern A.
        push_probe(1, 6,  0, 1, pat_a);
        push_probe(1, 7,  1, 1, pat_a);
        push_probe(1, 8,  1, 1, pat_a);
        push_probe(1, 9,  1, 1, pat_a);
        push_probe(1, 37, 1, 1, pat_a);
        drain();

        // Change grid mid-frame; remainder of frame 1 keeps pattern A.
        wait_rel(1, 4 * (HV_S + 16 * 48));
        grid_s = pat_b;
        push_probe(1, 2,  20, 1, pat_a);
        push_probe(1, 38, 20, 1, pat_a);
        push_probe(1, 7,  31, 1, pat_a);
        push_probe(1, 36, 31, 1, pat_a);
        push_probe(1, 37, 31, 1, pat_a);
        push_probe(1, 38, 31, 1, pat_a);
        drain();
        check("fs_count_frame1", 32'(fs_cnt_s), 32'd1);

        // Frame 2 renders pattern B.
        push_probe(1, 7,  1,  2, pat_b);
        push_probe(1, 37, 30, 2, pat_b);
        push_probe(1, 7,  31, 2, pat_b);
        push_probe(1, 37, 31, 2, pat_b);
        drain();
        check("fs_count_frame2", 32'(fs_cnt_s), 32'd2);

        // Reset mid-frame while an FG pixel is on the output.
        reset_s = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_hsync", 32'(hsync_s), 32'd1);
        check("midrst_vsync", 32'(vsync_s), 32'd1);
        check("midrst_rgb",   32'(rgb_s),   32'd0);
        check("midrst_de",    32'(de_s),    32'd0);
        check("midrst_fs",    32'(fs_s),    32'd0);
        @(posedge clk);
        #1;
        reset_s = 1'b0;
        rel[1]  = cyc;

        // After reset: timing restarts and the snapshot is cleared.
        push_probe(1, 6,  0,  0, pat_0);
        push_probe(1, 41, 0,  0, pat_0);
        push_probe(1, 42, 0,  0, pat_0);
        push_probe(1, 7,  1,  0, pat_0);
        push_probe(1, 37, 31, 0, pat_0);
        drain();
        check("fs_count_after_reset", 32'(fs_cnt_s), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
